// File: rtl/id_ctrl_if.sv
// ID-stage to ID/EX control bundle interface for the RV32I decode controller.
// The pipeline front end acts as master; the decode controller is the slave.
interface id_ctrl_if #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 16
);
  logic [SIZE-1:0]  id_instr;
  logic             id_valid;
  logic             ex_flush;
  logic             hold;

  logic [2:0]       id_imm_sel;
  logic             id_illegal;
  logic             pc_stall;

  logic             ex_valid;
  logic [2:0]       ex_imm_sel;
  logic [4:0]       ex_rd;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [2:0]       ex_funct3;
  logic             ex_funct7b5;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_alu_src_imm;
  logic             ex_branch;
  logic             ex_jump;
  logic [1:0]       ex_wb_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_instr, id_valid, ex_flush, hold,
    input  id_imm_sel, id_illegal, pc_stall,
    input  ex_valid, ex_imm_sel, ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_funct7b5,
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm, ex_branch,
    input  ex_jump, ex_wb_sel, stall_cnt
  );

  modport slave (
    input  id_instr, id_valid, ex_flush, hold,
    output id_imm_sel, id_illegal, pc_stall,
    output ex_valid, ex_imm_sel, ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_funct7b5,
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm, ex_branch,
    output ex_jump, ex_wb_sel, stall_cnt
  );
endinterface

// File: rtl/id_ctrl_unit.sv
// Decode-stage controller: opcode decode, load-use hazard detection, ID/EX
// control register with hold/flush/stall priority, and a saturating stall counter.
module id_ctrl_unit #(
  parameter int size  = 32,
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     reset,
  id_ctrl_if.slave bus
);

  if (size != 32) begin : g_bad_size
    $error("id_ctrl_unit: only a 32-bit instruction width is supported");
  end

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic       valid;
    logic [2:0] imm_sel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_imm;
    logic       branch;
    logic       jump;
    logic [1:0] wb_sel;
  } ex_bundle_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  f_rd;
  logic [4:0]  f_rs1;
  logic [4:0]  f_rs2;
  logic        unused_instr_bits;

  assign instr             = bus.id_instr;
  assign opcode            = instr[6:0];
  assign f_rd              = instr[11:7];
  assign f_rs1             = instr[19:15];
  assign f_rs2             = instr[24:20];
  assign unused_instr_bits = ^{instr[31], instr[29:25]};

  logic [2:0] dec_imm_sel;
  logic       dec_legal;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_alu_src_imm;
  logic       dec_branch;
  logic       dec_jump;
  logic [1:0] dec_wb_sel;
  logic       use_rs1;
  logic       use_rs2;

  always_comb begin
    dec_imm_sel     = 3'd5;
    dec_legal       = 1'b1;
    dec_reg_write   = 1'b0;
    dec_mem_read    = 1'b0;
    dec_mem_write   = 1'b0;
    dec_alu_src_imm = 1'b0;
    dec_branch      = 1'b0;
    dec_jump        = 1'b0;
    dec_wb_sel      = 2'd0;
    use_rs1         = 1'b1;
    use_rs2         = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        dec_imm_sel     = 3'd0;
        dec_reg_write   = 1'b1;
        dec_mem_read    = 1'b1;
        dec_alu_src_imm = 1'b1;
        dec_wb_sel      = 2'd1;
      end
      OPC_OP_IMM: begin
        dec_imm_sel     = 3'd0;
        dec_reg_write   = 1'b1;
        dec_alu_src_imm = 1'b1;
      end
      OPC_JALR: begin
        dec_imm_sel     = 3'd0;
        dec_reg_write   = 1'b1;
        dec_jump        = 1'b1;
        dec_alu_src_imm = 1'b1;
        dec_wb_sel      = 2'd2;
      end
      OPC_STORE: begin
        dec_imm_sel     = 3'd1;
        dec_mem_write   = 1'b1;
        dec_alu_src_imm = 1'b1;
        use_rs2         = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm_sel = 3'd2;
        dec_branch  = 1'b1;
        use_rs2     = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_imm_sel     = 3'd3;
        dec_reg_write   = 1'b1;
        dec_alu_src_imm = 1'b1;
        use_rs1         = 1'b0;
      end
      OPC_JAL: begin
        dec_imm_sel   = 3'd4;
        dec_reg_write = 1'b1;
        dec_jump      = 1'b1;
        dec_wb_sel    = 2'd2;
        use_rs1       = 1'b0;
      end
      OPC_OP: begin
        dec_reg_write = 1'b1;
        use_rs2       = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  ex_bundle_t       ex_q, ex_d;
  ex_bundle_t       dec_bundle;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hazard;

  // Unused register fields are zeroed so EX only ever sees meaningful indices.
  always_comb begin
    dec_bundle             = '0;
    dec_bundle.valid       = 1'b1;
    dec_bundle.imm_sel     = dec_imm_sel;
    dec_bundle.rd          = dec_reg_write ? f_rd : 5'd0;
    dec_bundle.rs1         = use_rs1 ? f_rs1 : 5'd0;
    dec_bundle.rs2         = use_rs2 ? f_rs2 : 5'd0;
    dec_bundle.funct3      = instr[14:12];
    dec_bundle.funct7b5    = instr[30];
    dec_bundle.reg_write   = dec_reg_write;
    dec_bundle.mem_read    = dec_mem_read;
    dec_bundle.mem_write   = dec_mem_write;
    dec_bundle.alu_src_imm = dec_alu_src_imm;
    dec_bundle.branch      = dec_branch;
    dec_bundle.jump        = dec_jump;
    dec_bundle.wb_sel      = dec_wb_sel;
  end

  assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & bus.id_valid &
                  ((use_rs1 & (f_rs1 == ex_q.rd)) | (use_rs2 & (f_rs2 == ex_q.rd)));

  // Priority: hold freezes everything, flush beats a hazard, hazard inserts a bubble.
  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.hold) begin
      if (bus.ex_flush || hazard) begin
        ex_d = '0;
      end else if (bus.id_valid && dec_legal) begin
        ex_d = dec_bundle;
      end else begin
        ex_d = '0;
      end
      if (!bus.ex_flush && hazard && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.id_imm_sel     = dec_imm_sel;
  assign bus.id_illegal     = bus.id_valid & ~dec_legal;
  assign bus.pc_stall       = bus.hold | (hazard & ~bus.ex_flush);

  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_imm_sel     = ex_q.imm_sel;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_rs1         = ex_q.rs1;
  assign bus.ex_rs2         = ex_q.rs2;
  assign bus.ex_funct3      = ex_q.funct3;
  assign bus.ex_funct7b5    = ex_q.funct7b5;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_alu_src_imm = ex_q.alu_src_imm;
  assign bus.ex_branch      = ex_q.branch;
  assign bus.ex_jump        = ex_q.jump;
  assign bus.ex_wb_sel      = ex_q.wb_sel;
  assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: doc/id_ctrl_unit.md
Name: id_ctrl_unit

Overview:
- Decode-stage controller for the 5-stage RV32I pipeline.
- Decodes the IF/ID instruction and drives IMM_sel combinationally to the ID-stage immediate decoder.
- Detects load-use hazards and registers the ID/EX control bundle, with stall, flush and hold handling.
- Keeps a saturating stall-cycle counter for performance observation.

Parameters:
- size, 32, instruction width. Only 32 is legal.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_instr  input  size  instruction held in IF/ID.
- id_valid  input  1  IF/ID holds a real instruction.
- ex_flush  input  1  branch/jump taken in EX; squash ID.
- hold  input  1  global freeze (memory wait); all state keeps its value.
- id_imm_sel  output  3  combinational IMM_sel to the immediate decoder.
- id_illegal  output  1  combinational: id_valid and the opcode is unsupported.
- pc_stall  output  1  freeze PC and IF/ID.
- ex_valid  output  1  ID/EX slot is valid.
- ex_imm_sel  output  3  registered IMM_sel.
- ex_rd, ex_rs1, ex_rs2  output  5 each  registered register indices.
- ex_funct3  output  3  registered instr[14:12].
- ex_funct7b5  output  1  registered instr[30].
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm, ex_branch, ex_jump  output  1 each  registered controls.
- ex_wb_sel  output  2  0=ALU, 1=MEM, 2=PC+4.
- stall_cnt  output  CNT_W  load-use stall cycles.

Behaviour:
- Opcode decode (instr[6:0]) to imm_sel/controls:
  - LOAD 0000011: imm_sel 0, rw, mr, src_imm, wb 1.
  - OP-IMM 0010011: imm_sel 0, rw, src_imm, wb 0.
  - JALR 1100111: imm_sel 0, rw, jump, src_imm, wb 2.
  - STORE 0100011: imm_sel 1, mw, src_imm.
  - BRANCH 1100011: imm_sel 2, branch.
  - LUI 0110111 and AUIPC 0010111: imm_sel 3, rw, src_imm, wb 0.
  - JAL 1101111: imm_sel 4, rw, jump, wb 2.
  - OP 0110011: imm_sel 5 (decoder outputs zero), rw, wb 0.
  - Any other opcode: imm_sel 5, all controls 0, id_illegal=1 when id_valid.
- id_imm_sel is a pure function of id_instr and is driven even when id_valid=0.
- rd = instr[11:7] and is used only when reg_write is set.
- rs1 is used for all opcodes except LUI, AUIPC and JAL.
- rs2 is used only for OP, STORE and BRANCH.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (rs1 used & rs1==ex_rd, or rs2 used & rs2==ex_rd).
- Per-edge priority:
  1. hold=1: every register keeps its value; pc_stall=1.
  2. ex_flush=1: bubble into ID/EX (ex_valid=0, all ex_* controls 0); pc_stall=0; the hazard is ignored.
  3. Hazard: bubble into ID/EX; pc_stall=1; stall_cnt increments.
  4. Otherwise: ID/EX loads the decoded bundle; ex_valid = id_valid & ~id_illegal.
- A bubble forces ex_valid and every control bit to 0. ex_rd, ex_rs1, ex_rs2, ex_imm_sel, ex_funct3, ex_funct7b5 go to 0.
- An invalid or illegal ID slot also loads all-zero controls.
- pc_stall is combinational: hold | (hazard & ~ex_flush).
- Stall duration:
  - A load-use stall lasts exactly one cycle; after the bubble, ex_mem_read=0, so the hazard clears.
  - Back-to-back loads into the same consumer each stall once.
- stall_cnt saturates at 2^CNT_W-1 and never wraps. It does not count during hold or flush.
- Reset (reset=0, asynchronous): ex_valid and all ex_* outputs go to 0, and stall_cnt goes to 0.
  - Reset mid-stall discards the stalled instruction's bubble state; the first cycle after release sees an empty EX.
- Latency: ID to EX is one cycle, excluding stalls.

Test Plan:
- Reset: assert reset=0 mid-run with ex_valid=1 → all ex_* outputs 0 immediately (no clock), stall_cnt=0.
- Decode sweep: instructions 0x00500093 (addi), 0x00112223 (sw), 0x00208463 (beq), 0x123452B7 (lui), 0x008000EF (jal) → id_imm_sel 0, 1, 2, 3, 4. Next-cycle ex_* controls match the table; 0x0000007F → id_illegal=1 and ex_valid=0.
- Load-use: lw x5,0(x1) then add x6,x5,x7 → pc_stall=1 for one cycle, bubble (ex_valid=0). Add enters EX on the following cycle; stall_cnt=1. With rd=x0 the same sequence → no stall.
- Non-use: lw x5 then lui x5 (rs1 unused) → no stall. lw x5 then sw x5,0(x2) (rs2 match) → stall.
- Priority: hazard and ex_flush in the same cycle → bubble, pc_stall=0, stall_cnt unchanged. Add hold=1 → nothing changes, pc_stall=1.
- Saturation: CNT_W=2, force 5 hazards → stall_cnt sticks at 3.
